// File: rtl/serial_product_accumulator_pkg.sv
// Shared types and constants for the shift-add multiplier datapath.
package pkg_mult;

   localparam int DW = 8;
   localparam int PW = 2 * DW;
   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef logic [DW-1:0] val_t;
   typedef logic [PW-1:0] product_t;
   typedef logic [CW-1:0] cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_product_accumulator_bit_counter.sv
// Up-counter with clear and enable; flags the last multiplier bit (DW-1).
module serial_product_accumulator_bit_counter #(
   parameter int DW = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   logic [CW-1:0] count_q;

   // Count consumed bits; hold at the terminal value so it never wraps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= '0;
      end else if (i_clr) begin
         count_q <= '0;
      end else if (i_en && !o_last) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign o_last = (count_q == CW'(DW - 1));

endmodule

// File: rtl/serial_product_accumulator.sv
// Serial shift-add product accumulator: consumes DW multiplier bits, LSB
// first, and accumulates the shifted multiplicand for every 1 bit.
//
// Handshake: a request is accepted on a rising edge where i_start=1 and
// o_ready=1 (IDLE); o_load mirrors that acceptance combinationally so the
// multiplier shift register loads on the same edge. Requests while
// o_ready=0 are dropped, not queued. o_done is a single-cycle pulse with
// o_product valid; the product then holds until the next accepted start.
module serial_product_accumulator
   import pkg_mult::*;
#(
   parameter int DW = pkg_mult::DW
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [DW-1:0]   i_multiplicand,
   input  logic            i_lsb,
   output logic            o_load,
   output logic            o_ready,
   output logic            o_busy,
   output logic            o_done,
   output logic [2*DW-1:0] o_product,
   output logic [1:0]      o_dbg_state
);

   localparam int PW = 2 * DW;

   state_t          state_q;
   state_t          state_d;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   mcand_q;
   logic            run;
   logic            last_bit;

   assign run    = (state_q == ST_RUN);
   assign o_load = i_start && (state_q == ST_IDLE);

   serial_product_accumulator_bit_counter #(
      .DW (DW)
   ) u_bit_counter (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (o_load),
      .i_en   (run),
      .o_last (last_bit)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and status outputs.
   always_comb begin
      state_d = state_q;
      o_ready = 1'b0;
      o_busy  = 1'b0;
      o_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            o_ready = 1'b1;
            if (i_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            o_busy = 1'b1;
            if (last_bit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_done  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath: load on acceptance, then shift multiplicand and add on 1 bits.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         acc_q   <= '0;
         mcand_q <= '0;
      end else if (o_load) begin
         acc_q   <= '0;
         mcand_q <= {{DW{1'b0}}, i_multiplicand};
      end else if (run) begin
         if (i_lsb) begin
            acc_q <= acc_q + mcand_q;
         end
         mcand_q <= mcand_q << 1;
      end
   end

   assign o_product   = acc_q;
   assign o_dbg_state = state_q;

endmodule
